// File: rtl/apb_pkg.sv
// Shared APB definitions for the 4-bit-address / 8-bit-data requester and responder.
package apb_pkg;

  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_m_wait_timer.sv
// ACCESS-phase wait counter with expiry flag for the APB requester.
// Instantiated by apb_m only when APB_M_TIMEOUT_EN is defined.
module apb_m_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  // Count stalled ACCESS cycles; saturate at the expiry value.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule : apb_m_wait_timer

// File: rtl/apb_m.sv
// APB requester: valid/ready command port in, SETUP -> ACCESS sequencing out,
// one-cycle response strobe back. One outstanding transfer at a time.
// Optional ACCESS-phase timeout abort: define APB_M_TIMEOUT_EN.
module apb_m
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  apb_state_e        state_q, state_d;
  logic              psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              timeout_hit;

`ifdef APB_M_TIMEOUT_EN
  logic wait_expired;

  apb_m_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (state_q != ACCESS),
    .tick    (state_q == ACCESS && !pready),
    .expired (wait_expired)
  );

  assign timeout_hit = (state_q == ACCESS) && !pready && wait_expired;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // A new command may enter from IDLE or on the completing ACCESS cycle.
  assign cmd_ready = (state_q == IDLE) || (state_q == ACCESS && pready);

  // Next-state and next-output decode for the registered APB/response outputs.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite ? '0 : prdata;
          if (cmd_valid) begin
            state_d   = SETUP;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_wdata;
          end else begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else if (timeout_hit) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge pclk or posedge preset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (preset) begin
      state_q   <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule : apb_m

// File: tb/tb_apb_m.sv
// Self-checking bench for apb_m: random commands, behavioural responder,
// scoreboard of expected APB transfers and responses, protocol monitor.
module tb_apb_m;

`ifdef APB_M_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
  } apb_exp_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_exp_t;

  logic       pclk = 1'b0;
  logic       preset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       psel, penable, pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;

  int cmp_count  = 0;
  int fail_count = 0;
  int b2b_seen   = 0;

  apb_exp_t   exp_apb[$];
  rsp_exp_t   exp_rsp[$];
  int         wait_q[$];
  logic [7:0] ref_mem  [16];
  logic [7:0] resp_mem [16];

  apb_m #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_psel"},      32'(psel),      32'd0);
    check({tag, "_penable"},   32'(penable),   32'd0);
    check({tag, "_pwrite"},    32'(pwrite),    32'd0);
    check({tag, "_paddr"},     32'(paddr),     32'd0);
    check({tag, "_pwdata"},    32'(pwdata),    32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  // Offer one command; junk rides on the cmd bus while the DUT is busy so an
  // early latch would show up on paddr/pwdata. Expectations are pushed on accept.
  task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d, input int waits);
    int       tries = 0;
    bit       done  = 1'b0;
    rsp_exp_t r;
    while (!done) begin
      @(negedge pclk);
      cmd_valid = 1'b1;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 4'($urandom_range(0, 15));
      cmd_wdata = 8'($urandom_range(0, 255));
      #1;
      if (cmd_ready) begin
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        exp_apb.push_back('{w: w, a: a, d: d});
        wait_q.push_back(waits);
        if (TO_EN && waits >= TIMEOUT) begin
          r = '{rdata: 8'h00, err: 1'b1};
        end else if (w) begin
          ref_mem[a] = d;
          r = '{rdata: 8'h00, err: 1'b0};
        end else begin
          r = '{rdata: ref_mem[a], err: 1'b0};
        end
        exp_rsp.push_back(r);
        done = 1'b1;
      end else begin
        tries++;
        if (tries > 100) begin
          cmp_count++;
          fail_count++;
          $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", tries);
          cmd_valid = 1'b0;
          return;
        end
      end
    end
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Behavioural responder: per-transfer wait count, memory updated on completion.
  int wait_left = 0;
  initial begin
    pready = 1'b0;
    prdata = 8'h00;
    forever begin
      @(negedge pclk);
      prdata = 8'($urandom_range(0, 255));
      if (preset) begin
        pready    = 1'b0;
        wait_left = 0;
      end else if (psel && !penable) begin
        wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        pready    = 1'($urandom_range(0, 1));
      end else if (psel && penable) begin
        if (wait_left == 0) begin
          pready = 1'b1;
          if (pwrite) resp_mem[paddr] = pwdata;
          else        prdata = resp_mem[paddr];
        end else begin
          pready = 1'b0;
          wait_left--;
        end
      end else begin
        pready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: samples late in each cycle and checks phase order, stability and responses.
  initial begin
    bit       p_setup  = 1'b0;
    bit       p_access = 1'b0;
    bit       p_pready = 1'b0;
    bit       p_abort, setup_now, access_now;
    int       acc_cnt  = 0;
    apb_exp_t cur      = '0;
    apb_exp_t e;
    rsp_exp_t r;
    forever begin
      @(negedge pclk);
      #3;
      if (preset) begin
        p_setup  = 1'b0;
        p_access = 1'b0;
        p_pready = 1'b0;
        acc_cnt  = 0;
        continue;
      end
      setup_now  = psel && !penable;
      access_now = psel && penable;
      p_abort    = p_access && !p_pready && TO_EN && (acc_cnt == TIMEOUT);

      check("rsp_valid_timing", 32'(rsp_valid), 32'((p_access && p_pready) || p_abort));
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          cmp_count++;
          fail_count++;
          $display("FAIL rsp_unexpected: got rsp_valid with rdata %0h, expected no response", rsp_rdata);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
          check("rsp_err",   32'(rsp_err),   32'(r.err));
        end
      end

      check("penable_without_psel", 32'(penable && !psel), 32'd0);
      if (p_setup)                     check("setup_one_cycle", 32'(access_now), 32'd1);
      else if (p_access && !p_pready)  check("access_hold", 32'(access_now), 32'(!p_abort));
      else                             check("access_needs_setup", 32'(access_now), 32'd0);

      if (p_access && p_pready && setup_now) b2b_seen++;

      if (setup_now) begin
        if (exp_apb.size() == 0) begin
          cmp_count++;
          fail_count++;
          $display("FAIL apb_unexpected: got SETUP addr %0h, expected idle", paddr);
        end else begin
          e = exp_apb.pop_front();
          check("setup_fields", 32'({pwrite, paddr, pwdata}), 32'(e));
          cur = e;
        end
      end
      if (access_now) begin
        check("access_stable", 32'({pwrite, paddr, pwdata}), 32'(cur));
        acc_cnt = p_setup ? 1 : acc_cnt + 1;
      end

      p_setup  = setup_now;
      p_access = access_now;
      p_pready = pready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Main stimulus: reset, directed plan items, random traffic, drain.
  initial begin
    logic [7:0] v;
    bit         seen;
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 4'h0;
    cmd_wdata = 8'h00;
    for (int i = 0; i < 16; i++) begin
      v           = 8'($urandom_range(0, 255));
      ref_mem[i]  = v;
      resp_mem[i] = v;
    end
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write, then read with three wait states.
    issue(1'b1, 4'h3, 8'hA5, 0);
    issue(1'b0, 4'h3, 8'h00, 3);
    repeat (8) @(negedge pclk);

    // Back-to-back: second command offered while the first is in SETUP.
    issue(1'b1, 4'h1, 8'h11, 0);
    check("cmd_ready_in_setup", 32'(cmd_ready), 32'd0);
    issue(1'b0, 4'h1, 8'h00, 0);
    repeat (6) @(negedge pclk);

    // Reset during a stalled ACCESS drops the transfer.
    issue(1'b0, 4'h5, 8'h00, 10);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge pclk);
      #1;
      seen = psel && penable;
    end
    check("reach_access_before_reset", 32'(seen), 32'd1);
    preset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    exp_apb.delete();
    exp_rsp.delete();
    wait_q.delete();
    @(negedge pclk);
    #1;
    preset = 1'b0;
    issue(1'b0, 4'h1, 8'h00, 1);
    repeat (6) @(negedge pclk);

    // Random traffic: mixed directions, waits (some long), gaps incl. back-to-back.
    for (int i = 0; i < 150; i++) begin
      int waits;
      waits = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), waits);
      repeat ($urandom_range(0, 2)) @(negedge pclk);
    end

    repeat (60) @(negedge pclk);
    check("apb_queue_drained", 32'(exp_apb.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    check("b2b_observed", 32'(b2b_seen != 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule : tb_apb_m
